// File: rtl/multicycle_ctrl_pkg.sv
// multicycle_ctrl_pkg: opcodes, FSM states, ALU/WB encodings and halt patterns for the RV32I multi-cycle controller.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_ERR} state_e;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_BEQ  = 4'b1001;
    localparam logic [3:0] ALU_BNE  = 4'b1010;
    localparam logic [3:0] ALU_BLT  = 4'b1011;
    localparam logic [3:0] ALU_BGE  = 4'b1100;
    localparam logic [3:0] ALU_BLTU = 4'b1110;
    localparam logic [3:0] ALU_BGEU = 4'b1111;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    localparam logic [31:0] NOP_IR      = 32'h0000_0013;
    localparam logic [31:0] HALT_PRE_IR = 32'h00c0_0093;
    localparam logic [31:0] HALT_IR     = 32'h0000_8067;

    function automatic logic [3:0] br_op(input logic [2:0] f3);
        return f3 == 3'b000 ? ALU_BEQ  :
               f3 == 3'b001 ? ALU_BNE  :
               f3 == 3'b100 ? ALU_BLT  :
               f3 == 3'b101 ? ALU_BGE  :
               f3 == 3'b110 ? ALU_BLTU :
               f3 == 3'b111 ? ALU_BGEU : ALU_ADD;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3);
        return f3 == 3'b000 ? 4'b0001 :
               f3 == 3'b001 ? 4'b0011 :
               f3 == 3'b010 ? 4'b1111 : 4'b0000;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_imm_gen.sv
// multicycle_ctrl_imm_gen: sign-extended immediate for I/S/B/U/J formats, selected by opcode.
module multicycle_ctrl_imm_gen
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] ir_i,
    output logic [31:0] imm_o
);
    logic [6:0]  opc;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opc   = ir_i[6:0];
    assign imm_i = {{20{ir_i[31]}}, ir_i[31:20]};
    assign imm_s = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
    assign imm_b = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
    assign imm_u = {ir_i[31:12], 12'b0};
    assign imm_j = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};

    assign imm_o = opc == OPC_STORE                      ? imm_s :
                   opc == OPC_BRANCH                     ? imm_b :
                   (opc == OPC_LUI || opc == OPC_AUIPC) ? imm_u :
                   opc == OPC_JAL                        ? imm_j : imm_i;
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle control FSM (IF/ID/EX/MEM/WB) with latency stretching, retire and halt detection.
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: trap unknown opcodes / bad store widths into S_ERR and expose ILLEGAL.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_LAT = 0,
    parameter int unsigned DMEM_LAT = 0
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic [31:0] INSTR,
    input  logic        BR_COND,
    output logic [31:0] IR,
    output logic [31:0] IMM,
    output logic [4:0]  RF_RA1,
    output logic [4:0]  RF_RA2,
    output logic [4:0]  RF_WA1,
    output logic [3:0]  OP,
    output logic        ALU_A_SEL,
    output logic        ALU_B_SEL,
    output logic [1:0]  WB_SEL,
    output logic        PC_SEL,
    output logic        PC_WE,
    output logic        RF_WE,
    output logic        D_MEM_WEN,
    output logic [3:0]  D_MEM_BE,
    output logic [2:0]  LFUNCT,
    output logic        RETIRE,
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    output logic        ILLEGAL,
`endif
    output logic        HALT
);
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] ir_q, ir_d, prev_ir_q, prev_ir_d;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic is_lui, is_auipc, is_jal, is_jalr, is_br, is_load, is_store, is_opimm, is_op, known;
    logic last_if, last_mem, retire;

    assign opc      = ir_q[6:0];
    assign f3       = ir_q[14:12];
    assign is_lui   = opc == OPC_LUI;
    assign is_auipc = opc == OPC_AUIPC;
    assign is_jal   = opc == OPC_JAL;
    assign is_jalr  = opc == OPC_JALR;
    assign is_br    = opc == OPC_BRANCH;
    assign is_load  = opc == OPC_LOAD;
    assign is_store = opc == OPC_STORE;
    assign is_opimm = opc == OPC_OPIMM;
    assign is_op    = opc == OPC_OP;
    assign known    = is_lui | is_auipc | is_jal | is_jalr | is_br | is_load | is_store | is_opimm | is_op;

    // One counter serves both IF and MEM; it is zero whenever neither state is active.
    assign last_if  = cnt_q == 4'(IMEM_LAT);
    assign last_mem = cnt_q == 4'(DMEM_LAT);
    assign retire   = state_q == S_WB || (state_q == S_MEM && is_store && last_mem) ||
                      (state_q == S_EX && is_br);

    multicycle_ctrl_imm_gen u_imm_gen (.ir_i(ir_q), .imm_o(IMM));

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IF;
            cnt_q     <= '0;
            ir_q      <= NOP_IR;
            prev_ir_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ir_q      <= ir_d;
            prev_ir_q <= prev_ir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        ir_d      = ir_q;
        prev_ir_d = retire ? ir_q : prev_ir_q;
        case (state_q)
            S_IF: begin
                if (last_if) begin
                    state_d = S_ID;
                    ir_d    = INSTR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_ID: begin
                if (ir_q == HALT_IR && prev_ir_q == HALT_PRE_IR)
                    state_d = S_HALT;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                else if (!known || (is_store && f3 > 3'd2))
                    state_d = S_ERR;
`endif
                else
                    state_d = S_EX;
            end
            S_EX:  state_d = (is_load || is_store) ? S_MEM : is_br ? S_IF : S_WB;
            S_MEM: begin
                if (last_mem) state_d = is_store ? S_IF : S_WB;
                else          cnt_d   = cnt_q + 4'd1;
            end
            S_WB:    state_d = S_IF;
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        OP        = is_op    ? {ir_q[30], f3} :
                    is_opimm ? {f3 == 3'b101 && ir_q[30], f3} :
                    is_br    ? br_op(f3) : ALU_ADD;
        ALU_A_SEL = is_auipc | is_jal;
        ALU_B_SEL = !(is_op | is_br);
        WB_SEL    = is_load ? WB_MEM : (is_jal | is_jalr) ? WB_PC4 : is_lui ? WB_IMM : WB_ALU;
        PC_SEL    = is_jal | is_jalr | (is_br & BR_COND);
        D_MEM_BE  = is_store ? store_be(f3) : 4'b0000;
    end

    assign IR        = ir_q;
    assign RF_RA1    = ir_q[19:15];
    assign RF_RA2    = ir_q[24:20];
    assign RF_WA1    = ir_q[11:7];
    assign LFUNCT    = f3;
    assign PC_WE     = retire;
    assign RETIRE    = retire;
    assign RF_WE     = state_q == S_WB && known && ir_q[11:7] != 5'd0;
    assign D_MEM_WEN = !(state_q == S_MEM && is_store && last_mem);
    assign HALT      = state_q == S_HALT;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    assign ILLEGAL   = state_q == S_ERR;
`endif
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I core. It latches each fetched instruction, decodes it, and sequences the instruction through IF/ID/EX/MEM/WB states. It drives the register-file, PC, ALU and data-memory enables per state, and stretches IF and MEM to match configurable memory latencies. It replaces the single-cycle combinational decoder, sitting between the I-memory read port and the datapath muxes, and adds instruction-retire and halt detection.

## Interface
- IMEM_LAT, 0, extra wait cycles after IF before INSTR is valid (0..15)
- DMEM_LAT, 0, extra wait cycles in MEM before load data / store completes (0..15)
- CLK  input  1  core clock, all state on rising edge
- RSTn  input  1  asynchronous, active-low reset
- INSTR  input  32  I-memory read data, sampled on last IF cycle
- BR_COND  input  1  ALU branch comparison result, valid in EX of a branch
- IR  output  32  latched instruction register
- IMM  output  32  sign-extended immediate from IR (I/S/B/U/J formats)
- RF_RA1, RF_RA2, RF_WA1  output  5  register addresses from IR
- OP  output  4  ALU op: {funct7[5],funct3} for ALU ops (funct7[5] honoured for I-type only on funct3=101); ADD 0000 for address/LUI/AUIPC/jumps; 1001/1010/1011/1100/1110/1111 for BEQ/BNE/BLT/BGE/BLTU/BGEU
- ALU_A_SEL  output  1  0=rs1, 1=PC
- ALU_B_SEL  output  1  0=rs2, 1=IMM
- WB_SEL  output  2  0=ALU, 1=load data, 2=PC+4, 3=IMM (LUI)
- PC_SEL  output  1  0=PC+4, 1=ALU result (JAL, JALR with bit0 cleared, taken branch)
- PC_WE, RF_WE  output  1  write enables, single-cycle pulses
- D_MEM_WEN  output  1  active-low store enable
- D_MEM_BE  output  4  byte enable: SB 0001, SH 0011, SW 1111
- LFUNCT  output  3  IR funct3 for load extension
- RETIRE  output  1  one-cycle pulse on each instruction's final cycle
- HALT  output  1  sticky halt flag

## Operation
- States: S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT (+ S_ERR with macro).
- S_IF: wait counter counts 0..IMEM_LAT; on final count IR<=INSTR, go S_ID.
- S_ID: decode IR; RF reads addressed. Next state is S_EX, except S_HALT on halt pattern.
- Paths:
  - ALU R/I, LUI, AUIPC, JAL, JALR: IF→ID→EX→WB.
  - Load: IF→ID→EX→MEM→WB.
  - Store: IF→ID→EX→MEM→IF.
  - Branch: IF→ID→EX→IF.
- S_MEM: counter 0..DMEM_LAT. Store holds D_MEM_WEN=0 only on the final MEM cycle; D_MEM_BE is valid throughout.
- Final cycle of every instruction (WB, store MEM-final, branch EX) asserts PC_WE and RETIRE.
- PC_SEL=1 for JAL/JALR and for a branch with BR_COND=1; otherwise 0. RF_WE=1 in WB only, and never when RF_WA1=0.
- Halt: IR=0x00008067 in S_ID and previously retired IR=0x00c00093 → S_HALT.
  - No PC_WE/RF_WE/RETIRE for the halting instruction.
  - HALT=1 until reset.
- Unknown opcode without macro: treated as NOP (ID→EX→WB with RF_WE=0, PC_SEL=0, RETIRE=1).

## Timing
- Reset: state S_IF; counters 0; IR=0x00000013; previous-IR register 0.
- Output reset values: PC_WE=0, RF_WE=0, RETIRE=0, HALT=0, D_MEM_WEN=1, D_MEM_BE=0. Decoded outputs reflect the NOP IR.
- Cycles per instruction with LAT=0: ALU/jump 4, load 5, store 4, branch 3. IF adds IMEM_LAT; MEM adds DMEM_LAT.
- All enables are Moore outputs of state and IR; no enable depends combinationally on INSTR.
- RSTn assertion mid-instruction aborts it immediately: no partial write completes after the reset edge.
- Counters saturate to 0 on state exit; LAT=15 must not wrap.

## Configuration
- MULTICYCLE_CTRL_ILLEGAL_TRAP_EN:
  - Defined: unknown opcode, or store funct3>2, in S_ID → S_ERR. S_ERR asserts output ILLEGAL=1 (port exists only with the macro), suppresses all enables, and holds until reset.
  - Undefined: NOP behaviour above; store funct3>2 gives D_MEM_BE=0.

## Structure
- Package multicycle_ctrl_pkg holds:
  - opcode constants
  - state enum
  - ALU OP codes
  - WB_SEL encodings
  - halt pattern constants
- Sub-module imm_gen: combinational IR→IMM for all five formats.

## Test plan
- ADDI x1,x0,5 (0x00500093), LAT=0 → RETIRE after 4 cycles; RF_WE=1 in cycle 4 with WA1=1, OP=0000, ALU_B_SEL=1.
- LW x2,8(x0), DMEM_LAT=3 → MEM lasts 4 cycles; WB_SEL=1; LFUNCT=010; RETIRE in cycle 8.
- SB x1,3(x0) → D_MEM_BE=0001, D_MEM_WEN=0 exactly one cycle, no RF_WE, PC_WE same cycle.
- BEQ with BR_COND=1 → OP=1001, PC_SEL=1, PC_WE in cycle 3; BR_COND=0 → PC_SEL=0.
- 0x00c00093 then 0x00008067 → HALT=1, no further PC_WE; mid-IF RSTn pulse → state S_IF, HALT=0.
- Opcode 0x7F → with macro ILLEGAL=1 and no enables; without macro RETIRE=1, RF_WE=0.
